// File: rtl/rv32i_pkg.sv
// rtl/rv32i_pkg.sv - shared RV32I types and MEM-stage helper functions
package rv32i_pkg;

  localparam int DPW = 32;

  // funct3 codes for loads and stores; 011/110/111 are not legal sizes
  typedef enum logic [2:0] {
    MEM_B  = 3'b000,
    MEM_H  = 3'b001,
    MEM_W  = 3'b010,
    MEM_BU = 3'b100,
    MEM_HU = 3'b101
  } mem_size_t;

  // Pick the addressed byte/halfword out of a word and extend it.
  // Halfwords are selected by lane[1] only and words ignore the lane.
  // Any misalignment has already been dealt with by the caller.
  function automatic logic [DPW-1:0] load_extend(input logic [31:0] word,
                                                 input logic [1:0]  lane,
                                                 input logic [2:0]  size);
    logic [7:0]  b;
    logic [15:0] h;
    logic [DPW-1:0] r;
    b = word[{lane, 3'b000} +: 8];
    h = lane[1] ? word[31:16] : word[15:0];
    case (size)
      MEM_B:   r = {{24{b[7]}}, b};
      MEM_H:   r = {{16{h[15]}}, h};
      MEM_W:   r = word;
      MEM_BU:  r = {24'd0, b};
      MEM_HU:  r = {16'd0, h};
      default: r = '0;
    endcase
    return r;
  endfunction

  // Byte-enable mask for a store of the given size at the given lane
  function automatic logic [3:0] store_be(input logic [1:0] lane,
                                          input logic [2:0] size);
    logic [3:0] be;
    case (size)
      MEM_B:   be = 4'b0001 << lane;
      MEM_H:   be = lane[1] ? 4'b1100 : 4'b0011;
      MEM_W:   be = 4'b1111;
      default: be = 4'b0000;
    endcase
    return be;
  endfunction

  // Halfword access at an odd byte, or word access off a word boundary
  function automatic logic is_misaligned(input logic [1:0] lane,
                                         input logic [2:0] size);
    logic m;
    case (size)
      MEM_H, MEM_HU: m = lane[0];
      MEM_W:         m = (lane != 2'b00);
      default:       m = 1'b0;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/dmem.sv
// rtl/dmem.sv - data RAM, byte-enable synchronous write, combinational read
module dmem #(
  parameter int MAW = 8
) (
  input  logic           clk,
  input  logic           we,
  input  logic [MAW-1:0] addr,
  input  logic [3:0]     be,
  input  logic [31:0]    wdata,
  output logic [31:0]    rdata
);

  localparam int DMEM_DEPTH = 2 ** MAW;

  logic [31:0] mem [0:DMEM_DEPTH-1];

  // Write only the enabled byte lanes; contents survive reset
  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) begin
          mem[addr][8*i +: 8] <= wdata[8*i +: 8];
        end
      end
    end
  end

  // Read sees the pre-write contents during the cycle of a write
  assign rdata = mem[addr];

endmodule

// File: rtl/memory_stage.sv
// rtl/memory_stage.sv - RV32I MEM stage: data memory access, MEM/WB register, writeback mux; optional MISALIGN_TRAP_EN
module memory_stage
  import rv32i_pkg::*;
#(
  parameter int MAW = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           regwriteM,
  input  logic           resultsrcM,
  input  logic           memwriteM,
  input  logic [2:0]     funct3M,
  input  logic [DPW-1:0] aluresultM,
  input  logic [DPW-1:0] Rd2M,
  input  logic [4:0]     RdM,
  output logic           regwriteW,
  output logic [4:0]     RdW,
  output logic [DPW-1:0] aluresultW,
  output logic [DPW-1:0] readdataW,
  output logic [DPW-1:0] resultW
`ifdef MISALIGN_TRAP_EN
  ,
  output logic           misalignW
`endif
);

  logic [1:0]     lane;
  logic [MAW-1:0] wordIdx;
  logic [3:0]     byteEn;
  logic [31:0]    storeData;
  logic [31:0]    memRdata;
  logic           memWe;
  logic           misAccess;
  logic [DPW-1:0] loadData;
  logic           resultsrcW;

  assign lane    = aluresultM[1:0];
  assign wordIdx = aluresultM[MAW+1:2];

`ifdef MISALIGN_TRAP_EN
  // Only real accesses can be misaligned; stores exist for SH/SW only
  assign misAccess = is_misaligned(lane, funct3M) &
                     (resultsrcM |
                      (memwriteM & ((funct3M == MEM_H) | (funct3M == MEM_W))));
`else
  assign misAccess = 1'b0;
`endif

  // Replicate store data across lanes so the byte mask alone picks the target
  always_comb begin
    storeData = Rd2M;
    case (funct3M)
      MEM_B:   storeData = {4{Rd2M[7:0]}};
      MEM_H:   storeData = {2{Rd2M[15:0]}};
      default: storeData = Rd2M;
    endcase
  end

  assign byteEn = store_be(lane, funct3M);
  assign memWe  = memwriteM & ~rst & ~misAccess;

  dmem #(
    .MAW(MAW)
  ) u_dmem (
    .clk  (clk),
    .we   (memWe),
    .addr (wordIdx),
    .be   (byteEn),
    .wdata(storeData),
    .rdata(memRdata)
  );

  // Non-loads and trapped loads produce zero so readdataW is deterministic
  always_comb begin
    loadData = '0;
    if (resultsrcM && !misAccess) begin
      loadData = load_extend(memRdata, lane, funct3M);
    end
  end

  // MEM/WB pipeline register, no stall or flush
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      regwriteW  <= 1'b0;
      resultsrcW <= 1'b0;
      RdW        <= 5'd0;
      aluresultW <= '0;
      readdataW  <= '0;
    end else begin
      regwriteW  <= regwriteM & ~misAccess;
      resultsrcW <= resultsrcM;
      RdW        <= RdM;
      aluresultW <= aluresultM;
      readdataW  <= loadData;
    end
  end

`ifdef MISALIGN_TRAP_EN
  // Flag stays high for exactly the W cycle of the offending access
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      misalignW <= 1'b0;
    end else begin
      misalignW <= misAccess;
    end
  end
`endif

  assign resultW = resultsrcW ? readdataW : aluresultW;

endmodule

// File: tb/tb_memory_stage.sv
// tb/tb_memory_stage.sv - self-checking bench for memory_stage
module tb_memory_stage;

  localparam int DEPTH = 256;

  logic        clk;
  logic        rst;
  logic        regwriteM;
  logic        resultsrcM;
  logic        memwriteM;
  logic [2:0]  funct3M;
  logic [31:0] aluresultM;
  logic [31:0] Rd2M;
  logic [4:0]  RdM;
  logic        regwriteW;
  logic [4:0]  RdW;
  logic [31:0] aluresultW;
  logic [31:0] readdataW;
  logic [31:0] resultW;
`ifdef MISALIGN_TRAP_EN
  logic        misalignW;
`endif

  int errors = 0;
  int checks = 0;

  logic [31:0] model [DEPTH];

  memory_stage #(.MAW(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .regwriteM (regwriteM),
    .resultsrcM(resultsrcM),
    .memwriteM (memwriteM),
    .funct3M   (funct3M),
    .aluresultM(aluresultM),
    .Rd2M      (Rd2M),
    .RdM       (RdM),
    .regwriteW (regwriteW),
    .RdW       (RdW),
    .aluresultW(aluresultW),
    .readdataW (readdataW),
    .resultW   (resultW)
`ifdef MISALIGN_TRAP_EN
    ,
    .misalignW (misalignW)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: what the W outputs must be one edge after this M-cycle,
  // then the memory update the store implies.
  task automatic step(input logic mw, input logic rs, input logic rw,
                      input logic [2:0] f3, input logic [31:0] addr,
                      input logic [31:0] data, input logic [4:0] rd);
    int          idx;
    int          lane;
    logic [31:0] w;
    logic [31:0] b;
    logic [31:0] h;
    logic [31:0] expRd;
    logic [31:0] keep;
    logic        mis;
    regwriteM  = rw;
    resultsrcM = rs;
    memwriteM  = mw;
    funct3M    = f3;
    aluresultM = addr;
    Rd2M       = data;
    RdM        = rd;
    idx  = int'((addr / 4) % DEPTH);
    lane = int'(addr % 4);
    mis  = 1'b0;
`ifdef MISALIGN_TRAP_EN
    if (rs && (((f3 == 3'd1 || f3 == 3'd5) && (lane % 2 == 1)) || (f3 == 3'd2 && lane != 0)))
      mis = 1'b1;
    if (mw && ((f3 == 3'd1 && (lane % 2 == 1)) || (f3 == 3'd2 && lane != 0)))
      mis = 1'b1;
`endif
    w = model[idx];
    b = (w >> (8 * lane)) & 32'hFF;
    h = (lane >= 2) ? (w >> 16) : (w & 32'hFFFF);
    case (f3)
      3'd0:    expRd = (b >= 128) ? (b + 32'hFFFFFF00) : b;
      3'd1:    expRd = (h >= 32768) ? (h + 32'hFFFF0000) : h;
      3'd2:    expRd = w;
      3'd4:    expRd = b;
      3'd5:    expRd = h;
      default: expRd = 0;
    endcase
    if (!rs || mis) expRd = 0;
    if (mw && !mis) begin
      case (f3)
        3'd0: begin
          keep = ~(32'hFF << (8 * lane));
          model[idx] = (w & keep) | ((data & 32'hFF) << (8 * lane));
        end
        3'd1: begin
          if (lane >= 2) model[idx] = (w & 32'h0000FFFF) | (data << 16);
          else           model[idx] = (w & 32'hFFFF0000) | (data & 32'hFFFF);
        end
        3'd2:    model[idx] = data;
        default: ;
      endcase
    end
    @(posedge clk);
    #1;
    chk("regwriteW", {31'd0, regwriteW}, {31'd0, rw && !mis});
    chk("RdW", {27'd0, RdW}, {27'd0, rd});
    chk("aluresultW", aluresultW, addr);
    chk("readdataW", readdataW, expRd);
    chk("resultW", resultW, rs ? expRd : addr);
`ifdef MISALIGN_TRAP_EN
    chk("misalignW", {31'd0, misalignW}, {31'd0, mis});
`endif
  endtask

  typedef struct {
    logic        mw;
    logic        rs;
    logic        rw;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] data;
    logic [4:0]  rd;
    logic [31:0] expRes;
  } vec_t;

  vec_t vecs[$];

  initial begin
    rst = 1'b0; regwriteM = 0; resultsrcM = 0; memwriteM = 0;
    funct3M = 0; aluresultM = 0; Rd2M = 0; RdM = 0;
    #1 rst = 1'b1;
    #1;
    chk("reset regwriteW", {31'd0, regwriteW}, 32'd0);
    chk("reset RdW", {27'd0, RdW}, 32'd0);
    chk("reset aluresultW", aluresultW, 32'd0);
    chk("reset readdataW", readdataW, 32'd0);
    chk("reset resultW", resultW, 32'd0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;

    // Known contents everywhere: word i holds A50000ii
    for (int i = 0; i < DEPTH; i++) step(1, 0, 0, 3'd2, 32'(i * 4), 32'hA5000000 | 32'(i), 0);

    vecs.push_back('{1, 0, 0, 3'd2, 32'h10,  32'hDEADBEEF, 5'd0,  32'h10});
    vecs.push_back('{0, 1, 1, 3'd2, 32'h10,  32'h0,        5'd5,  32'hDEADBEEF});
    vecs.push_back('{1, 0, 0, 3'd2, 32'h20,  32'h0,        5'd0,  32'h20});
    vecs.push_back('{1, 0, 0, 3'd0, 32'h23,  32'h12345680, 5'd0,  32'h23});
    vecs.push_back('{1, 0, 0, 3'd1, 32'h20,  32'hABCDF00F, 5'd0,  32'h20});
    vecs.push_back('{0, 1, 1, 3'd2, 32'h20,  32'h0,        5'd6,  32'h8000F00F});
    vecs.push_back('{0, 1, 1, 3'd0, 32'h23,  32'h0,        5'd7,  32'hFFFFFF80});
    vecs.push_back('{0, 1, 1, 3'd4, 32'h23,  32'h0,        5'd8,  32'h00000080});
    vecs.push_back('{0, 1, 1, 3'd1, 32'h20,  32'h0,        5'd9,  32'hFFFFF00F});
    vecs.push_back('{0, 1, 1, 3'd5, 32'h20,  32'h0,        5'd10, 32'h0000F00F});
    vecs.push_back('{0, 1, 1, 3'd3, 32'h20,  32'h0,        5'd11, 32'h0});
    vecs.push_back('{1, 0, 0, 3'd1, 32'h22,  32'h00001234, 5'd0,  32'h22});
    vecs.push_back('{0, 1, 1, 3'd5, 32'h22,  32'h0,        5'd12, 32'h00001234});
`ifdef MISALIGN_TRAP_EN
    vecs.push_back('{0, 1, 1, 3'd1, 32'h23,  32'h0,        5'd13, 32'h0});
`else
    vecs.push_back('{0, 1, 1, 3'd1, 32'h23,  32'h0,        5'd13, 32'h00001234});
`endif
    vecs.push_back('{0, 0, 1, 3'd0, 32'h12345678, 32'h0,   5'd14, 32'h12345678});
    vecs.push_back('{0, 1, 1, 3'd2, 32'h278, 32'h0,        5'd15, 32'hA500009E});
    vecs.push_back('{1, 0, 0, 3'd2, 32'h400, 32'hCAFEF00D, 5'd0,  32'h400});
    vecs.push_back('{0, 1, 1, 3'd2, 32'h0,   32'h0,        5'd0,  32'hCAFEF00D});
    vecs.push_back('{1, 0, 0, 3'd2, 32'h30,  32'h0,        5'd0,  32'h30});
    vecs.push_back('{1, 0, 1, 3'd2, 32'h31,  32'h11111111, 5'd2,  32'h31});
`ifdef MISALIGN_TRAP_EN
    vecs.push_back('{0, 1, 1, 3'd2, 32'h30,  32'h0,        5'd16, 32'h0});
`else
    vecs.push_back('{0, 1, 1, 3'd2, 32'h30,  32'h0,        5'd16, 32'h11111111});
`endif
    // Load and store to one word in one cycle: load sees the old data
    vecs.push_back('{1, 1, 1, 3'd2, 32'h10,  32'h5A5A5A5A, 5'd17, 32'hDEADBEEF});
    vecs.push_back('{0, 1, 1, 3'd2, 32'h10,  32'h0,        5'd18, 32'h5A5A5A5A});

    foreach (vecs[i]) begin
      step(vecs[i].mw, vecs[i].rs, vecs[i].rw, vecs[i].f3, vecs[i].addr, vecs[i].data, vecs[i].rd);
      chk($sformatf("vec%0d resultW", i), resultW, vecs[i].expRes);
    end

    // Asynchronous reset with a store pending; store must not land
    step(1, 0, 0, 3'd2, 32'h40, 32'h55AA55AA, 0);
    regwriteM = 1; resultsrcM = 0; memwriteM = 1; funct3M = 3'd2;
    aluresultM = 32'h40; Rd2M = 32'h99999999; RdM = 5'd3;
    #3 rst = 1'b1;
    #1;
    chk("async rst aluresultW", aluresultW, 32'd0);
    chk("async rst RdW", {27'd0, RdW}, 32'd0);
    chk("async rst resultW", resultW, 32'd0);
    @(posedge clk); #1;
    chk("held rst regwriteW", {31'd0, regwriteW}, 32'd0);
    chk("held rst resultW", resultW, 32'd0);
    rst = 1'b0;
    step(1, 0, 0, 3'd2, 32'h44, 32'h77777777, 0);
    step(0, 1, 1, 3'd2, 32'h40, 0, 5'd4);
    chk("post-rst word 0x40", resultW, 32'h55AA55AA);
    step(0, 1, 1, 3'd2, 32'h44, 0, 5'd4);
    chk("deassert-cycle store 0x44", resultW, 32'h77777777);

    // Randomised traffic against the reference
    for (int n = 0; n < 400; n++) begin
      logic [31:0] a;
      logic [1:0]  kind;
      kind = 2'($urandom_range(0, 3));
      a = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, 127));
      step(kind == 2'd1 || kind == 2'd3, kind == 2'd2 || kind == 2'd3,
           1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), a, $urandom,
           5'($urandom_range(0, 31)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
